sram_blwl_bank_prog: RTL
========================

// Module: sram_blwl_bank_prog
// PURPOSE
//  Upstream programming controller for a bank of BL/WL-programmed SRAM cells.
//  Accepts one row-wide configuration word per valid/ready handshake.
//  Drives it onto the shared bit lines, then fires a single one-hot word-line
//  pulse so the addressed row captures the data on the WL rising edge.
//  Steps rows 0..NUM_WL-1 in order and flags completion after the last row.
// PARAMETERS
//  NUM_BL          8  bit lines (columns); cfg_data width
//  NUM_WL          8  word lines (rows) in the bank; >=2
//  SETUP_CYCLES    1  cycles BL is stable before WL rises; >=1
//  PULSE_CYCLES    2  cycles WL is held high; >=1
// PORTS
//  clk        in   1             single clock; all state changes on posedge
//  rst        in   1             async, active-high reset
//  cfg_valid  in   1             cfg_data valid
//  cfg_ready  out  1             controller can accept a word
//  cfg_data   in   NUM_BL        row data; bit i drives bl[i]
//  cfg_clear  in   1             synchronous restart of row pointer (IDLE only)
//  bl         out  NUM_BL        bit-line drive to bank
//  wl         out  NUM_WL        word-line drive, one-hot or zero
//  row        out  clog2(NUM_WL) row the next accepted word is written to
//  busy       out  1             high in SETUP/PULSE/HOLD
//  done       out  1             1-cycle pulse after row NUM_WL-1 is written
// BEHAVIOUR
//  Reset (async): state=IDLE, bl=0, wl=0, row=0, busy=0, done=0.
//   cfg_ready is high after reset (IDLE).
//  All outputs are registered; wl never glitches and is never multi-hot.
//  FSM states: IDLE, SETUP, PULSE, HOLD.
//  IDLE: cfg_ready=1.
//   Handshake when cfg_valid & cfg_ready at edge T:
//   bl<=cfg_data, go to SETUP, cnt=0.
//   cfg_data is sampled only on that edge.
//  SETUP: cfg_ready=0, wl=0, bl held.
//   After SETUP_CYCLES cycles, go to PULSE and set wl[row]=1.
//  PULSE: wl[row]=1 for exactly PULSE_CYCLES cycles, bl held.
//   Then clear wl and go to HOLD.
//  HOLD: 1 cycle, wl=0, bl still held (hold margin for the cell latch).
//   Then go to IDLE.
//   If row==NUM_WL-1: row<=0 and done=1 for 1 cycle; else row<=row+1.
//  Timing per word with acceptance at edge T:
//   bl valid T+1;
//   wl high T+1+SETUP_CYCLES .. T+SETUP_CYCLES+PULSE_CYCLES;
//   cfg_ready high again T+SETUP_CYCLES+PULSE_CYCLES+2.
//   Throughput is one word per SETUP_CYCLES+PULSE_CYCLES+2 cycles.
//  bl keeps its last value in IDLE; it changes only on handshake or reset.
//  cfg_clear:
//   In IDLE it sets row<=0, no done.
//   If cfg_clear and cfg_valid are both high in IDLE, clear wins:
//    no handshake, cfg_ready stays 1.
//   Ignored outside IDLE.
//  cfg_valid while busy is ignored (ready=0); the word must be held until accepted.
//  Reset mid-operation: wl drops to 0 asynchronously, row=0, partial row not counted.
//  Counters are sized clog2(max(SETUP_CYCLES,PULSE_CYCLES)+1).
//   The row counter wraps exactly at NUM_WL-1 and never reaches NUM_WL.
// TESTING
//  Reset with NUM_WL=8: release rst
//   -> bl=0, wl=0, row=0, cfg_ready=1, done=0.
//  Single word 8'hA5 at T, default params
//   -> bl=8'hA5 at T+1; wl=8'h01 at T+2,T+3; wl=0 at T+4; cfg_ready=1 at T+5; row=1.
//  Eight back-to-back words, valid held high
//   -> wl pulses 01,02,..,80 in order.
//   -> done=1 for one cycle with the 8th HOLD exit, then row=0.
//   -> Cell model (posedge wl captures bl) holds all 8 words.
//  Assert rst during PULSE of row 3
//   -> wl=0 immediately, row=0; next word programs row 0.
//  cfg_clear with cfg_valid in IDLE at row 5
//   -> row=0, no handshake, no wl activity, done stays 0.
//  SETUP_CYCLES=3, PULSE_CYCLES=1
//   -> wl high exactly 1 cycle, starting 4 cycles after acceptance.
//   -> bl unchanged from T+1 through the HOLD cycle.

Source files
------------

// File: rtl/sram_blwl_bank_prog_if.sv
// Configuration word handshake between an upstream source and the BL/WL bank programmer.
// Pure wiring; adds no latency.
// The source holds cfg_valid/cfg_data until it sees cfg_ready high on a clock edge.
interface sram_blwl_bank_prog_if #(
    parameter int NUM_BL = 8
);
    logic              cfg_valid;
    logic              cfg_ready;
    logic              cfg_clear;
    logic [NUM_BL-1:0] cfg_data;

    // Upstream side: offers words and restart requests.
    modport master (
        output cfg_valid,
        output cfg_data,
        output cfg_clear,
        input  cfg_ready
    );

    // Controller side: consumes words.
    modport slave (
        input  cfg_valid,
        input  cfg_data,
        input  cfg_clear,
        output cfg_ready
    );
endinterface

// File: rtl/sram_blwl_bank_prog.sv
// Programs one SRAM row per accepted word: drive bit lines, then a single one-hot word-line pulse.
// Latency: bl valid 1 cycle after accept, wl high after SETUP_CYCLES more, ready again after SETUP+PULSE+2.
// Backpressure: cfg_ready is low from accept until the HOLD cycle has finished; cfg_valid is ignored meanwhile.
module sram_blwl_bank_prog #(
    parameter int NUM_BL       = 8,
    parameter int NUM_WL       = 8,
    parameter int SETUP_CYCLES = 1,
    parameter int PULSE_CYCLES = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    sram_blwl_bank_prog_if.slave      cfg,
    output logic [NUM_BL-1:0]         bl,
    output logic [NUM_WL-1:0]         wl,
    output logic [$clog2(NUM_WL)-1:0] row,
    output logic                      busy,
    output logic                      done
);

    localparam int ROW_W   = $clog2(NUM_WL);
    localparam int CNT_MAX = (SETUP_CYCLES > PULSE_CYCLES) ? SETUP_CYCLES : PULSE_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [ROW_W-1:0]  ROW_LAST   = ROW_W'(NUM_WL - 1);
    localparam logic [CNT_W-1:0]  SETUP_LAST = CNT_W'(SETUP_CYCLES - 1);
    localparam logic [CNT_W-1:0]  PULSE_LAST = CNT_W'(PULSE_CYCLES - 1);
    localparam logic [NUM_WL-1:0] WL_ONE     = NUM_WL'(1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SETUP = 2'd1,
        PULSE = 2'd2,
        HOLD  = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q,   cnt_d;
    logic [NUM_BL-1:0]   bl_q,    bl_d;
    logic [NUM_WL-1:0]   wl_q,    wl_d;
    logic [ROW_W-1:0]    row_q,   row_d;
    logic                busy_q,  busy_d;
    logic                done_q,  done_d;
    logic                ready_q, ready_d;

    // Next-state and next-output computation; every output is a flop so wl cannot glitch.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bl_d    = bl_q;
        wl_d    = wl_q;
        row_d   = row_q;
        busy_d  = busy_q;
        ready_d = ready_q;
        done_d  = 1'b0;

        case (state_q)
            IDLE: begin
                // A clear request takes priority over a pending word.
                if (cfg.cfg_clear) begin
                    row_d = '0;
                end else if (cfg.cfg_valid) begin
                    bl_d    = cfg.cfg_data;
                    cnt_d   = '0;
                    state_d = SETUP;
                    ready_d = 1'b0;
                    busy_d  = 1'b1;
                end
            end
            SETUP: begin
                if (cnt_q == SETUP_LAST) begin
                    cnt_d   = '0;
                    wl_d    = WL_ONE << row_q;
                    state_d = PULSE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            PULSE: begin
                if (cnt_q == PULSE_LAST) begin
                    cnt_d   = '0;
                    wl_d    = '0;
                    state_d = HOLD;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            HOLD: begin
                // bl stays driven this cycle so the cell latch sees data after WL falls.
                state_d = IDLE;
                ready_d = 1'b1;
                busy_d  = 1'b0;
                if (row_q == ROW_LAST) begin
                    row_d  = '0;
                    done_d = 1'b1;
                end else begin
                    row_d = row_q + ROW_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
                wl_d    = '0;
                ready_d = 1'b1;
                busy_d  = 1'b0;
            end
        endcase
    end

    // FSM and output registers; reset drops wl immediately and discards a partial row.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            bl_q    <= '0;
            wl_q    <= '0;
            row_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            ready_q <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bl_q    <= bl_d;
            wl_q    <= wl_d;
            row_q   <= row_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            ready_q <= ready_d;
        end
    end

    assign cfg.cfg_ready = ready_q;
    assign bl            = bl_q;
    assign wl            = wl_q;
    assign row           = row_q;
    assign busy          = busy_q;
    assign done          = done_q;

endmodule
